// File: rtl/fpadd_seq.sv
// Queues fp add/sub operand pairs and drives one multi-cycle adder over start/done, returning sums with a watchdog.
// Latency: two cycles from an accepted push into an empty queue to add_start, then adder time plus one cycle to out_valid.
// Backpressure: in_ready drops when the queue is full; a result is held stable in HOLD until out_ready.
module fpadd_seq #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        out_err,
    output logic        add_start,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_sum,
    input  logic        add_done,
    output logic        busy,
    output logic [15:0] op_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [31:0]   QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t        state;
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [TW-1:0] timer;
    logic [63:0]   head;
    logic          q_empty;
    logic          q_full;
    logic          push;
    logic          pop;

    assign q_empty  = (count == '0);
    assign q_full   = (count == FULL_CNT);
    assign in_ready = !q_full;
    assign push     = in_valid && !q_full;
    assign pop      = (state == IDLE) && !q_empty;
    assign head     = mem[rd_ptr];
    assign busy     = (state != IDLE) || !q_empty;

    // Subtraction is folded into the queued operand so the adder only ever adds.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b[31] ^ in_sub, in_b[30:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // add_start is high exactly while in ISSUE; the adder clears done on that edge,
    // so the first WAIT cycle already reflects the new operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            add_start <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            timer     <= '0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_sum   <= '0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!q_empty) begin
                        add_a     <= head[63:32];
                        add_b     <= head[31:0];
                        add_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    add_start <= 1'b0;
                    timer     <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (add_done) begin
                        out_sum   <= add_sum;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else if (timer == TMO_LAST) begin
                        out_sum   <= QNAN;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpadd_seq.sv
// Scoreboard bench for fpadd_seq with a behavioural multi-cycle adder that can be told to hang.
module tb_fpadd_seq;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_err;
    logic        add_start;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_sum;
    logic        add_done;
    logic        busy;
    logic [15:0] op_count;

    logic        model_done = 1'b0;
    logic        force_done = 1'b0;
    assign add_done = model_done | force_done;

    fpadd_seq #(.DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_err(out_err),
        .add_start(add_start), .add_a(add_a), .add_b(add_b),
        .add_sum(add_sum), .add_done(add_done),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [32:0] exp_q[$];
    logic [63:0] iss_q[$];
    int          exp_ops  = 0;
    int          n_starts = 0;
    int          delay    = 10;
    int          cnt      = 0;
    int          since    = 0;
    bit          tracking = 0;
    bit          hang     = 0;
    bit          acc      = 0;
    bit          prev_ov  = 0;
    bit          prev_rdy = 0;
    bit          prev_st  = 0;
    logic [31:0] held_sum = '0;
    logic        held_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (a == 32'h4040_0000 && b == 32'hBF80_0000) return 32'h4000_0000;
        return a ^ {b[15:0], b[31:16]};
    endfunction

    // One clock: observe at the negedge (adder model + scoreboard), return just after the posedge.
    task automatic step();
        logic [31:0] b2;
        logic [32:0] e;
        logic [63:0] op;
        @(negedge clk);
        acc = 0;
        if (reset) begin
            exp_q.delete();
            iss_q.delete();
            exp_ops = 0;
            prev_ov = 0;
            prev_st = 0;
        end else begin
            if (add_start) begin
                check("start_pulse_width", 32'(prev_st), 32'd0);
                if (iss_q.size() == 0) begin
                    check("spurious_start", 32'd1, 32'd0);
                end else begin
                    op = iss_q.pop_front();
                    check("add_a", add_a, op[63:32]);
                    check("add_b", add_b, op[31:0]);
                end
                model_done = 1'b0;
                cnt        = delay;
                since      = 0;
                tracking   = 1;
                n_starts++;
            end else begin
                if (tracking) since++;
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0 && !hang) begin
                        model_done = 1'b1;
                        add_sum    = fmodel(add_a, add_b);
                    end
                end
            end
            if (out_valid && !prev_ov && tracking)
                check("result_latency", 32'(since), hang ? 32'(TIMEOUT + 1) : 32'(delay + 1));
            if (out_valid && prev_ov && !prev_rdy) begin
                check("hold_sum", out_sum, held_sum);
                check("hold_err", 32'(out_err), 32'(held_err));
                check("hold_no_start", 32'(add_start), 32'd0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_sum", out_sum, e[31:0]);
                    check("out_err", 32'(out_err), 32'(e[32]));
                end
                exp_ops++;
            end
            if (in_valid && in_ready) begin
                acc = 1;
                b2  = {in_b[31] ^ in_sub, in_b[30:0]};
                iss_q.push_back({in_a, b2});
                exp_q.push_back(hang ? {1'b1, 32'h7FC0_0000} : {1'b0, fmodel(in_a, b2)});
            end
            prev_ov  = out_valid;
            prev_rdy = out_ready;
            prev_st  = add_start;
            held_sum = out_sum;
            held_err = out_err;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub);
        int k;
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
        k = 0;
        do begin
            step();
            k++;
        end while (!acc && k < 500);
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        bit done = 0;
        for (int k = 0; k < bound && !done; k++) begin
            step();
            if (!busy && !out_valid) done = 1;
        end
        if (!done) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n_acc;
        bit seen;
        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
        out_ready = 1'b1; add_sum = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", out_sum, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_add_start", 32'(add_start), 32'd0);
        check("rst_add_ab", add_a | add_b, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);

        // Plain add, then subtract with the sign of B flipped before issue.
        send(32'h3F80_0000, 32'h4000_0000, 1'b0);
        wait_idle(200);
        check("t1_starts", 32'(n_starts), 32'd1);
        check("t1_op_count", 32'(op_count), 32'(exp_ops));
        send(32'h4040_0000, 32'h3F80_0000, 1'b1);
        wait_idle(200);
        check("t2_op_count", 32'(op_count), 32'd2);

        // Hung adder, consumer stalled: one in flight plus a full queue, then in_ready stays low.
        hang = 1; out_ready = 1'b0; n_acc = 0;
        in_a = 32'h4100_0000; in_b = 32'h3F00_0000; in_sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 150; i++) begin
            step();
            if (acc) begin
                n_acc++;
                in_a   = 32'h4100_0000 + 32'(n_acc);
                in_sub = n_acc[0];
            end
        end
        check("t3_accepted", 32'(n_acc), 32'd5);
        check("t3_in_ready_full", 32'(in_ready), 32'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        wait_idle(1000);
        check("t3_op_count", 32'(op_count), 32'd7);

        // Single timeout, then a normal op recovers.
        send(32'h4120_0000, 32'h4130_0000, 1'b0);
        wait_idle(300);
        hang = 0;
        send(32'h3F80_0000, 32'h4000_0000, 1'b0);
        wait_idle(200);
        check("t4_op_count", 32'(op_count), 32'd9);

        // Consumer holds off for 20 cycles in HOLD; stability checked every cycle.
        delay = 3; out_ready = 1'b0;
        send(32'h4200_0000, 32'hC100_0000, 1'b1);
        seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            step();
            if (out_valid) seen = 1;
        end
        check("t5_out_valid_seen", 32'(seen), 32'd1);
        repeat (20) step();
        check("t5_still_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        wait_idle(50);
        check("t5_op_count", 32'(op_count), 32'd10);

        // Reset in WAIT with a stale done and one op queued behind.
        hang = 1; delay = 10;
        send(32'h4300_0000, 32'h4310_0000, 1'b0);
        send(32'h4320_0000, 32'h4330_0000, 1'b0);
        repeat (5) step();
        reset = 1'b1; force_done = 1'b1;
        step();
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        check("t6_op_count", 32'(op_count), 32'd0);
        check("t6_add_start", 32'(add_start), 32'd0);
        reset = 1'b0; hang = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("t6_no_output", 32'(out_valid | add_start), 32'd0);
        end
        force_done = 1'b0;
        send(32'h3F80_0000, 32'h4000_0000, 1'b0);
        wait_idle(200);
        check("t6_op_count_after", 32'(op_count), 32'd1);
        check("sb_results_left", 32'(exp_q.size()), 32'd0);
        check("sb_issues_left", 32'(iss_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
